ddr_app_arbiter: RTL

Round-robin arbiter and sequencer between three DDR requesters and the single MIG 7-series user (app) interface. The requesters are PSC (index 0), DSC (index 1) and L2 (index 2). The block owns the app_* command, write-data and read-data handshakes. It allows one transaction in flight at a time and returns completion, read data and error status to the granted requester. It sits between the cache/stream controllers and the DDR3 controller instance, in the ui_clk domain.

---
 rtl/ddr_app_arbiter_if.sv | 34 +++
 rtl/ddr_app_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ddr_app_arbiter_if.sv
// rtl/ddr_app_arbiter_if.sv - MIG 7-series user (app) interface bundle
//   master : arbiter side (drives app_addr/cmd/en and write data, receives rdy and read data)
//   slave  : MIG side
//   o_app_*  arbiter -> MIG: address, command, enable, write data/strobe/end/mask
//   i_app_*  MIG -> arbiter: command ready, write FIFO ready, read data and valid

interface ddr_app_arbiter_if #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 128
);
  logic [ADDR_WIDTH-1:0]   o_app_addr;
  logic [2:0]              o_app_cmd;
  logic                    o_app_en;
  logic                    i_app_rdy;
  logic [DATA_WIDTH-1:0]   o_app_wdf_data;
  logic                    o_app_wdf_wren;
  logic                    o_app_wdf_end;
  logic [DATA_WIDTH/8-1:0] o_app_wdf_mask;
  logic                    i_app_wdf_rdy;
  logic [DATA_WIDTH-1:0]   i_app_rd_data;
  logic                    i_app_rd_data_valid;

  modport master (
    output o_app_addr, o_app_cmd, o_app_en,
    output o_app_wdf_data, o_app_wdf_wren, o_app_wdf_end, o_app_wdf_mask,
    input  i_app_rdy, i_app_wdf_rdy, i_app_rd_data, i_app_rd_data_valid
  );

  modport slave (
    input  o_app_addr, o_app_cmd, o_app_en,
    input  o_app_wdf_data, o_app_wdf_wren, o_app_wdf_end, o_app_wdf_mask,
    output i_app_rdy, i_app_wdf_rdy, i_app_rd_data, i_app_rd_data_valid
  );
endinterface

// File: rtl/ddr_app_arbiter.sv
// rtl/ddr_app_arbiter.sv - round-robin arbiter/sequencer of PSC, DSC and L2 onto the MIG app interface
//   clk_166M66, mcu_sys_rst     : ui_clk and synchronous active-high reset
//   i_req/i_rw/i_addr/i_wdata   : per-requester request, direction (1=write), address, write data
//   o_grant/o_ack/o_err/o_rdata : owner one-hot, completion pulse, read-timeout flag, read data
//   i_init_calib_complete       : MIG calibration done; gates new grants only
//   app                         : MIG app command / write-data / read-data handshakes

module ddr_app_arbiter #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 128,
  parameter int RD_TIMEOUT = 255,
  parameter int TO_WIDTH   = 8
) (
  input  logic                    clk_166M66,
  input  logic                    mcu_sys_rst,
  input  logic [2:0]              i_req,
  input  logic [2:0]              i_rw,
  input  logic [3*ADDR_WIDTH-1:0] i_addr,
  input  logic [3*DATA_WIDTH-1:0] i_wdata,
  output logic [2:0]              o_grant,
  output logic [2:0]              o_ack,
  output logic                    o_err,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  input  logic                    i_init_calib_complete,
  ddr_app_arbiter_if.master       app
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WDATA  = 3'd1;
  localparam logic [2:0] S_CMD    = 3'd2;
  localparam logic [2:0] S_RDWAIT = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(RD_TIMEOUT - 1);
  localparam logic [TO_WIDTH-1:0] TO_ONE  = {{(TO_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]            state_q,    state_d;
  logic [1:0]            ptr_q,      ptr_d;
  logic                  rw_q,       rw_d;
  logic [TO_WIDTH-1:0]   to_cnt_q,   to_cnt_d;
  logic [2:0]            grant_q,    grant_d;
  logic [2:0]            ack_q,      ack_d;
  logic                  err_q,      err_d;
  logic [DATA_WIDTH-1:0] rdata_q,    rdata_d;
  logic [ADDR_WIDTH-1:0] app_addr_q, app_addr_d;
  logic [2:0]            app_cmd_q,  app_cmd_d;
  logic                  app_en_q,   app_en_d;
  logic [DATA_WIDTH-1:0] wdf_data_q, wdf_data_d;
  logic                  wdf_wren_q, wdf_wren_d;

  // Round-robin scan order after the last owner: ptr+1, ptr+2, ptr (all mod 3).
  logic [1:0]            cand1, cand2, win_idx;
  logic                  sel_rw;
  logic [2:0]            sel_grant;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  always_comb begin
    cand1 = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
    cand2 = (cand1 == 2'd2) ? 2'd0 : cand1 + 2'd1;
    if (i_req[cand1])      win_idx = cand1;
    else if (i_req[cand2]) win_idx = cand2;
    else                   win_idx = ptr_q;
  end

  always_comb begin
    case (win_idx)
      2'd1: begin
        sel_rw    = i_rw[1];
        sel_grant = 3'b010;
        sel_addr  = i_addr[ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = i_wdata[DATA_WIDTH +: DATA_WIDTH];
      end
      2'd2: begin
        sel_rw    = i_rw[2];
        sel_grant = 3'b100;
        sel_addr  = i_addr[2*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = i_wdata[2*DATA_WIDTH +: DATA_WIDTH];
      end
      default: begin
        sel_rw    = i_rw[0];
        sel_grant = 3'b001;
        sel_addr  = i_addr[0 +: ADDR_WIDTH];
        sel_wdata = i_wdata[0 +: DATA_WIDTH];
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    to_cnt_d   = to_cnt_q;
    grant_d    = grant_q;
    ack_d      = 3'b000;
    err_d      = err_q;
    rdata_d    = rdata_q;
    app_addr_d = app_addr_q;
    app_cmd_d  = app_cmd_q;
    app_en_d   = app_en_q;
    wdf_data_d = wdf_data_q;
    wdf_wren_d = wdf_wren_q;

    case (state_q)
      S_IDLE: begin
        if (i_init_calib_complete && (|i_req)) begin
          ptr_d      = win_idx;
          grant_d    = sel_grant;
          rw_d       = sel_rw;
          app_addr_d = sel_addr;
          app_cmd_d  = {2'b00, ~sel_rw};
          wdf_data_d = sel_wdata;
          // Outputs for the next state are registered here so they appear in cycle 1.
          if (sel_rw) begin
            wdf_wren_d = 1'b1;
            state_d    = S_WDATA;
          end else begin
            app_en_d   = 1'b1;
            state_d    = S_CMD;
          end
        end
      end

      S_WDATA: begin
        if (app.i_app_wdf_rdy) begin
          wdf_wren_d = 1'b0;
          app_en_d   = 1'b1;
          state_d    = S_CMD;
        end
      end

      S_CMD: begin
        if (app_en_q && app.i_app_rdy) begin
          app_en_d = 1'b0;
          if (rw_q) begin
            err_d   = 1'b0;
            ack_d   = grant_q;
            state_d = S_DONE;
          end else begin
            to_cnt_d = '0;
            state_d  = S_RDWAIT;
          end
        end
      end

      S_RDWAIT: begin
        if (app.i_app_rd_data_valid) begin
          rdata_d = app.i_app_rd_data;
          err_d   = 1'b0;
          ack_d   = grant_q;
          state_d = S_DONE;
        end else if (to_cnt_q == TO_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          ack_d   = grant_q;
          state_d = S_DONE;
        end else begin
          to_cnt_d = to_cnt_q + TO_ONE;
        end
      end

      S_DONE: begin
        grant_d = 3'b000;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_166M66) begin
    if (mcu_sys_rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= 2'd2;
      rw_q       <= 1'b0;
      to_cnt_q   <= '0;
      grant_q    <= 3'b000;
      ack_q      <= 3'b000;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      app_addr_q <= '0;
      app_cmd_q  <= 3'b000;
      app_en_q   <= 1'b0;
      wdf_data_q <= '0;
      wdf_wren_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      to_cnt_q   <= to_cnt_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      app_addr_q <= app_addr_d;
      app_cmd_q  <= app_cmd_d;
      app_en_q   <= app_en_d;
      wdf_data_q <= wdf_data_d;
      wdf_wren_q <= wdf_wren_d;
    end
  end

  assign o_grant            = grant_q;
  assign o_ack              = ack_q;
  assign o_err              = err_q;
  assign o_rdata            = rdata_q;
  assign app.o_app_addr     = app_addr_q;
  assign app.o_app_cmd      = app_cmd_q;
  assign app.o_app_en       = app_en_q;
  assign app.o_app_wdf_data = wdf_data_q;
  assign app.o_app_wdf_wren = wdf_wren_q;
  assign app.o_app_wdf_end  = wdf_wren_q;
  assign app.o_app_wdf_mask = '0;

endmodule
